legv8_multicycle_ctrl: RTL
==========================

# legv8_multicycle_ctrl

Multicycle control sequencer for the LEGv8 core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the datapath strobes. It selects the immediate format used by the sign-extension unit and runs the single shared memory port with a request/acknowledge handshake. It also detects illegal opcodes and memory timeouts, and counts retired instructions.

## Interface
- TIMEOUT_CYCLES, 255: maximum number of cycles a memory request may wait for memAck before the block faults.
- COUNT_WIDTH, 32: width of the retired-instruction counter.

Ports:
- clk, input, 1: the single clock; everything is rising-edge.
- rst_n, input, 1: asynchronous, active-low reset.
- instruction, input, 32: instruction register contents. Valid from DECODE onward.
- zeroFlag, input, 1: ALU zero result. Combinational within EXEC.
- memAck, input, 1: memory completion. A single-cycle pulse.
- memRead, output, 1: read request, held until memAck.
- memWrite, output, 1: write request, held until memAck.
- memSel, output, 1: 0 = instruction fetch, 1 = data access.
- irWrite, output, 1: loads the instruction register.
- pcWrite, output, 1: loads the PC.
- pcSrc, output, 1: 0 = PC+4; 1 = oldPC + (imm<<2).
- immSel, output, 2: immediate format. 0 = D-type, 1 = CBZ, 2 = B.
- aluSrcB, output, 1: 0 = register operand, 1 = immediate operand.
- aluOp, output, 4: 0 AND, 1 ORR, 2 ADD, 6 SUB, 7 PASSB.
- regWrite, output, 1: register file write enable.
- memToReg, output, 1: writeback selects memory data.
- fault, output, 1: sticky error flag.
- faultCode, output, 2: 1 = illegal opcode, 2 = memory timeout.
- retired, output, COUNT_WIDTH: count of completed instructions.

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=7.
- Reset values:
  - state = FETCH.
  - immSel = 0, the latched instruction class = none, retired = 0.
  - fault = 0, faultCode = 0, wait counter = 0.
  - All strobes deassert, with one exception: state is FETCH, so memRead=1 and memSel=0 immediately after reset.
- FETCH:
  - Drive memRead=1 and memSel=0.
  - In the memAck cycle, also drive irWrite=1, pcWrite=1 and pcSrc=0, then go to DECODE.
  - These three ack-cycle strobes are Mealy outputs; every other output is Moore.
- DECODE: classify instruction[31:21].
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000: class R.
  - LDUR 11111000010, STUR 11111000000: class D, immSel=0.
  - CBZ, matched on [31:24] = 10110100: immSel=1.
  - B, matched on [31:26] = 000101: immSel=2.
  - Match priority is B, then CBZ, then the 11-bit opcodes.
  - Any other encoding goes to FAULT with faultCode=1.
  - immSel and the class are latched here and held until the next DECODE.
- EXEC:
  - R-type: aluSrcB=0, aluOp from the opcode, then WB.
  - LDUR/STUR: aluSrcB=1, aluOp=ADD, then MEM.
  - CBZ: aluOp=PASSB. If zeroFlag=1, assert pcWrite with pcSrc=1. Go to FETCH and retire.
  - B: pcWrite=1, pcSrc=1, then FETCH and retire.
- MEM:
  - Drive memSel=1, plus memRead (LDUR) or memWrite (STUR).
  - On memAck: LDUR goes to WB; STUR goes to FETCH and retires.
- WB: regWrite=1, memToReg=1 for LDUR only, then FETCH and retire.
- Retire: retired increments by 1 on each transition into FETCH from EXEC, MEM or WB. It wraps modulo 2^COUNT_WIDTH.
- Timeout:
  - The wait counter clears on every entry to FETCH or MEM and increments each cycle without memAck.
  - When it reaches TIMEOUT_CYCLES, go to FAULT with faultCode=2.
  - memAck arriving in that same cycle wins: no fault.
- FAULT:
  - Absorbing state with all strobes at 0, fault=1 and faultCode held. Only rst_n exits it.
  - retired stops counting.
- memAck outside FETCH or MEM is ignored.
- Reset asserted mid-instruction clears all state immediately and asynchronously. No partial strobe survives.

## Timing
- All of the following assume memAck on the first request cycle.
- R-type and STUR take 4 cycles.
- LDUR takes 5 cycles.
- CBZ and B take 3 cycles.
- Each additional cycle of memory wait adds 1 cycle to latency.
- memRead/memWrite remain high from state entry through the memAck cycle inclusive, and drop the following cycle.
- pcWrite pulses at most twice per instruction: once at fetch and once at branch.
- The fault flag rises one cycle after the offending DECODE or timeout cycle.

## Test plan
- Fetch ADD (0x8B020020) with immediate acks: states 0,1,2,4. aluOp=2, regWrite=1 in the 4th cycle, retired=1.
- LDUR (0xF8408020) with a 3-cycle data ack delay: MEM held for 3 cycles with memRead=1 and memSel=1. immSel=0. WB has memToReg=1. Total 7 cycles.
- CBZ (0xB4000040) with zeroFlag=1, then zeroFlag=0: the first asserts pcWrite with pcSrc=1 in EXEC, the second does not. immSel=1 for both. retired advances by 2.
- B (0x14000010): immSel=2, EXEC pcWrite=1 with pcSrc=1, 3-cycle latency.
- Illegal word 0x00000000: FAULT, fault=1, faultCode=1. All strobes stay 0 for 20 further cycles despite memAck pulses.
- TIMEOUT_CYCLES=4 with memAck withheld in FETCH:
  - Fault with faultCode=2 after 4 waiting cycles.
  - Separate run with memAck arriving exactly in cycle 4: no fault.
  - Separate run asserting rst_n=0 mid-MEM: every output returns to its reset value with no clock edge.

Source files
------------

// File: rtl/legv8_multicycle_ctrl.sv
// legv8_multicycle_ctrl: multicycle FETCH/DECODE/EXEC/MEM/WB sequencer with a
// shared-memory request/ack handshake, illegal-opcode and timeout faults, and a retire counter.
module legv8_multicycle_ctrl #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int COUNT_WIDTH    = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [31:0]            instruction,
   input  logic                   zeroFlag,
   input  logic                   memAck,
   output logic                   memRead,
   output logic                   memWrite,
   output logic                   memSel,
   output logic                   irWrite,
   output logic                   pcWrite,
   output logic                   pcSrc,
   output logic [1:0]             immSel,
   output logic                   aluSrcB,
   output logic [3:0]             aluOp,
   output logic                   regWrite,
   output logic                   memToReg,
   output logic                   fault,
   output logic [1:0]             faultCode,
   output logic [COUNT_WIDTH-1:0] retired
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, FAULT = 3'd7} state_t;
   typedef enum logic [3:0] {C_NONE, C_ADD, C_SUB, C_AND, C_ORR, C_LDUR, C_STUR, C_CBZ, C_B} cls_t;
   state_t state_q, state_d;
   cls_t cls_q, cls_d, dec_cls;
   logic [1:0] imm_q, imm_d, fc_q, fc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [COUNT_WIDTH-1:0] ret_q, ret_d;
   logic mr_q, mw_q, ms_q, asb_q, rw_q, m2r_q, fault_q;
   logic [3:0] aop_q;
   logic mr_d, mw_d, ms_d, asb_d, rw_d, m2r_d, xs, tmo, br, ack_f;
   logic [3:0] aop_d;
   logic [10:0] op;
   logic unused_bits;
   assign unused_bits = ^instruction[20:0];
   assign op = instruction[31:21];
   // B outranks CBZ, which outranks the full 11-bit opcodes
   always_comb begin
      dec_cls = instruction[31:26] == 6'b000101   ? C_B    :
                instruction[31:24] == 8'b10110100 ? C_CBZ  :
                op == 11'b10001011000             ? C_ADD  :
                op == 11'b11001011000             ? C_SUB  :
                op == 11'b10001010000             ? C_AND  :
                op == 11'b10101010000             ? C_ORR  :
                op == 11'b11111000010             ? C_LDUR :
                op == 11'b11111000000             ? C_STUR : C_NONE;
   end
   assign tmo = !memAck && cnt_q == CW'(TIMEOUT_CYCLES - 1);
   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      imm_d   = imm_q;
      case (state_q)
         FETCH:  state_d = memAck ? DECODE : tmo ? FAULT : FETCH;
         DECODE: begin
            cls_d   = dec_cls;
            state_d = dec_cls == C_NONE ? FAULT : EXEC;
            imm_d   = dec_cls == C_B ? 2'd2 : dec_cls == C_CBZ ? 2'd1 : dec_cls == C_NONE ? imm_q : 2'd0;
         end
         EXEC:   state_d = (cls_q == C_LDUR || cls_q == C_STUR) ? MEM :
                           (cls_q == C_CBZ || cls_q == C_B) ? FETCH : WB;
         MEM:    state_d = memAck ? (cls_q == C_LDUR ? WB : FETCH) : tmo ? FAULT : MEM;
         WB:     state_d = FETCH;
         default: state_d = FAULT;
      endcase
      fc_d  = (state_d == FAULT && state_q != FAULT) ? (state_q == DECODE ? 2'd1 : 2'd2) : fc_q;
      cnt_d = (state_d != state_q && (state_d == FETCH || state_d == MEM)) ? '0 :
              ((state_q == FETCH || state_q == MEM) && !memAck) ? cnt_q + CW'(1) : cnt_q;
      ret_d = (state_d == FETCH && (state_q == EXEC || state_q == MEM || state_q == WB)) ?
              ret_q + COUNT_WIDTH'(1) : ret_q;
      // Moore strobes are precomputed from the next state so they leave a flop
      xs    = state_d == EXEC || state_d == MEM || state_d == WB;
      mr_d  = state_d == FETCH || (state_d == MEM && cls_d == C_LDUR);
      mw_d  = state_d == MEM && cls_d == C_STUR;
      ms_d  = state_d == MEM;
      asb_d = xs && (cls_d == C_LDUR || cls_d == C_STUR);
      aop_d = !xs               ? 4'd0 :
              cls_d == C_SUB    ? 4'd6 :
              cls_d == C_AND    ? 4'd0 :
              cls_d == C_ORR    ? 4'd1 :
              cls_d == C_CBZ    ? 4'd7 :
              cls_d == C_B      ? 4'd0 : 4'd2;
      rw_d  = state_d == WB;
      m2r_d = state_d == WB && cls_d == C_LDUR;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         cls_q   <= C_NONE;
         imm_q   <= 2'd0;
         fc_q    <= 2'd0;
         cnt_q   <= '0;
         ret_q   <= '0;
         mr_q    <= 1'b1;
         mw_q    <= 1'b0;
         ms_q    <= 1'b0;
         asb_q   <= 1'b0;
         aop_q   <= 4'd0;
         rw_q    <= 1'b0;
         m2r_q   <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         imm_q   <= imm_d;
         fc_q    <= fc_d;
         cnt_q   <= cnt_d;
         ret_q   <= ret_d;
         mr_q    <= mr_d;
         mw_q    <= mw_d;
         ms_q    <= ms_d;
         asb_q   <= asb_d;
         aop_q   <= aop_d;
         rw_q    <= rw_d;
         m2r_q   <= m2r_d;
         fault_q <= state_d == FAULT;
      end
   end
   // fetch-ack and branch strobes react to memAck/zeroFlag within the cycle
   assign ack_f     = state_q == FETCH && memAck;
   assign br        = state_q == EXEC && (cls_q == C_B || (cls_q == C_CBZ && zeroFlag));
   assign irWrite   = ack_f;
   assign pcWrite   = ack_f || br;
   assign pcSrc     = br;
   assign memRead   = mr_q;
   assign memWrite  = mw_q;
   assign memSel    = ms_q;
   assign immSel    = imm_q;
   assign aluSrcB   = asb_q;
   assign aluOp     = aop_q;
   assign regWrite  = rw_q;
   assign memToReg  = m2r_q;
   assign fault     = fault_q;
   assign faultCode = fc_q;
   assign retired   = ret_q;
endmodule
